// File: rtl/ptmch_cnt_pkg.sv
// Shared types and defaults for the ptmch trigger-pulse counter array.
package ptmch_cnt_pkg;

  localparam int unsigned PTMCH_NUM_CH      = 5;
  localparam int unsigned PTMCH_CNT_W       = 32;
  localparam int unsigned PTMCH_SYNC_STAGES = 2;

  typedef enum logic [1:0] {
    EDGE_RISE = 2'b00,
    EDGE_FALL = 2'b01,
    EDGE_BOTH = 2'b10,
    EDGE_OFF  = 2'b11
  } edge_sel_e;

  // Select which detected edge(s) form a channel event.
  function automatic logic edge_hit(input edge_sel_e sel, input logic rise, input logic fall);
    logic hit;
    hit = 1'b0;
    case (sel)
      EDGE_RISE: hit = rise;
      EDGE_FALL: hit = fall;
      EDGE_BOTH: hit = rise | fall;
      default:   hit = 1'b0;
    endcase
    return hit;
  endfunction

endpackage

// File: rtl/ptmch_trg_edge_det.sv
// One trigger channel: synchroniser chain, delay flop and edge-select decode.
module ptmch_trg_edge_det
  import ptmch_cnt_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = PTMCH_SYNC_STAGES
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      trg,
  input  edge_sel_e edge_sel,
  output logic      ev
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   dly_q;
  logic                   sync;
  logic                   rise;
  logic                   fall;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q <= '0;
      dly_q  <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], trg};
      dly_q  <= sync_q[SYNC_STAGES-1];
    end
  end

  assign sync = sync_q[SYNC_STAGES-1];
  assign rise = sync & ~dly_q;
  assign fall = ~sync & dly_q;

  // Decoded combinationally so the counter sees the edge on the next clock.
  always_comb begin
    ev = 1'b0;
    ev = edge_hit(edge_sel, rise, fall);
  end

endmodule

// File: rtl/ptmch_trg_cnt_array.sv
// Multi-channel trigger edge counter with per-channel clear, global enable and snapshot.
// Build option: define PTMCH_CNT_WRAP_EN for wrapping counters with a sticky overflow flag.
module ptmch_trg_cnt_array
  import ptmch_cnt_pkg::*;
#(
  parameter int unsigned NUM_CH      = PTMCH_NUM_CH,
  parameter int unsigned CNT_W       = PTMCH_CNT_W,
  parameter int unsigned SYNC_STAGES = PTMCH_SYNC_STAGES
) (
  input  logic                    CLK100M,
  input  logic                    RESET_N,
  input  logic [NUM_CH-1:0]       TRG_PLS,
  input  logic [2*NUM_CH-1:0]     EDGE_SEL,
  input  logic                    CNT_EN,
  input  logic [NUM_CH-1:0]       CLR_MASK,
  input  logic                    SNAP_REQ,
  output logic [NUM_CH*CNT_W-1:0] CNT_OUT,
  output logic [NUM_CH*CNT_W-1:0] SNAP_OUT,
  output logic                    SNAP_VLD,
  output logic [NUM_CH-1:0]       SAT_FLAG
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [NUM_CH-1:0] ev;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             sat_q;
    logic             sat_d;

    ptmch_trg_edge_det #(
      .SYNC_STAGES(SYNC_STAGES)
    ) u_edge_det (
      .clk      (CLK100M),
      .rst_n    (RESET_N),
      .trg      (TRG_PLS[g]),
      .edge_sel (edge_sel_e'(EDGE_SEL[2*g +: 2])),
      .ev       (ev[g])
    );

    // Clear beats everything; an event coincident with a clear is dropped.
    always_comb begin
      cnt_d = cnt_q;
      sat_d = sat_q;
      if (CLR_MASK[g]) begin
        cnt_d = '0;
        sat_d = 1'b0;
      end
`ifdef PTMCH_CNT_WRAP_EN
      else if (ev[g] && CNT_EN) begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_MAX) sat_d = 1'b1;
      end
`else
      else if (cnt_q == CNT_MAX) begin
        sat_d = 1'b1;
      end else if (ev[g] && CNT_EN) begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_d == CNT_MAX) sat_d = 1'b1;
      end
`endif
    end

    always_ff @(posedge CLK100M) begin
      if (!RESET_N) begin
        cnt_q <= '0;
        sat_q <= 1'b0;
      end else begin
        cnt_q <= cnt_d;
        sat_q <= sat_d;
      end
    end

    assign CNT_OUT[CNT_W*g +: CNT_W] = cnt_q;
    assign SAT_FLAG[g]               = sat_q;
  end

  // Snapshot captures pre-update counters, giving atomic read-and-clear with CLR_MASK.
  always_ff @(posedge CLK100M) begin
    if (!RESET_N) begin
      SNAP_OUT <= '0;
      SNAP_VLD <= 1'b0;
    end else begin
      SNAP_VLD <= SNAP_REQ;
      if (SNAP_REQ) SNAP_OUT <= CNT_OUT;
    end
  end

endmodule

// File: tb/tb_ptmch_trg_cnt_array.sv
// Scoreboard bench for ptmch_trg_cnt_array (4-bit counters to reach saturation quickly).
module tb_ptmch_trg_cnt_array;

  localparam int unsigned NUM_CH = 5;
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned SYNC   = 2;

  logic                    clk;
  logic                    rst_n;
  logic [NUM_CH-1:0]       trg;
  logic [2*NUM_CH-1:0]     edge_sel;
  logic                    cnt_en;
  logic [NUM_CH-1:0]       clr_mask;
  logic                    snap_req;
  logic [NUM_CH*CNT_W-1:0] cnt_out;
  logic [NUM_CH*CNT_W-1:0] snap_out;
  logic                    snap_vld;
  logic [NUM_CH-1:0]       sat_flag;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t sb_q[$];
  int   chk_cnt  = 0;
  int   pass_cnt = 0;

  ptmch_trg_cnt_array #(
    .NUM_CH(NUM_CH),
    .CNT_W(CNT_W),
    .SYNC_STAGES(SYNC)
  ) dut (
    .CLK100M  (clk),
    .RESET_N  (rst_n),
    .TRG_PLS  (trg),
    .EDGE_SEL (edge_sel),
    .CNT_EN   (cnt_en),
    .CLR_MASK (clr_mask),
    .SNAP_REQ (snap_req),
    .CNT_OUT  (cnt_out),
    .SNAP_OUT (snap_out),
    .SNAP_VLD (snap_vld),
    .SAT_FLAG (sat_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500us;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else pass_cnt++;
  endtask

  task automatic sb_push(input string tag, input logic [31:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sb_q.push_back(e);
  endtask

  task automatic sb_pop(input logic [31:0] got);
    exp_t e;
    if (sb_q.size() == 0) begin
      check_val("sb_empty", got, 32'hdead_beef);
    end else begin
      e = sb_q.pop_front();
      check_val(e.tag, got, e.val);
    end
  endtask

  function automatic logic [31:0] cnt_of(input int ch);
    return 32'(cnt_out[CNT_W*ch +: CNT_W]);
  endfunction

  function automatic logic [31:0] snap_of(input int ch);
    return 32'(snap_out[CNT_W*ch +: CNT_W]);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    trg      = '0;
    clr_mask = '0;
    snap_req = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic pulse(input logic [NUM_CH-1:0] mask);
    trg = trg | mask;
    repeat (3) tick();
    trg = trg & ~mask;
    repeat (3) tick();
  endtask

  task automatic flush();
    repeat (4) tick();
  endtask

  initial begin
    int waited;
    rst_n    = 1'b0;
    trg      = '0;
    edge_sel = '0;
    cnt_en   = 1'b1;
    clr_mask = '0;
    snap_req = 1'b0;
    tick();
    tick();
    check_val("rst_cnt",  32'(cnt_out),  32'h0);
    check_val("rst_snap", 32'(snap_out), 32'h0);
    check_val("rst_sat",  32'(sat_flag), 32'h0);
    check_val("rst_vld",  32'(snap_vld), 32'h0);
    rst_n = 1'b1;
    tick();

    // Latency: first sampled at edge N, increment visible after edge N+2.
    trg[0] = 1'b1;
    tick();
    check_val("lat_n",  cnt_of(0), 32'd0);
    tick();
    check_val("lat_n1", cnt_of(0), 32'd0);
    tick();
    check_val("lat_n2", cnt_of(0), 32'd1);
    trg[0] = 1'b0;
    repeat (3) tick();
    sb_push("rise_ch0", 32'd10);
    for (int c = 1; c < NUM_CH; c++) sb_push($sformatf("rise_ch%0d", c), 32'd0);
    repeat (9) pulse(5'b00001);
    flush();
    for (int c = 0; c < NUM_CH; c++) sb_pop(cnt_of(c));

    // Edge select: ch1 fall, ch2 both, ch3 off.
    do_reset();
    edge_sel = 10'b00_11_10_01_00;
    sb_push("fall_ch1", 32'd4);
    sb_push("both_ch2", 32'd8);
    sb_push("off_ch3",  32'd0);
    repeat (4) pulse(5'b01110);
    flush();
    for (int c = 1; c < 4; c++) sb_pop(cnt_of(c));
    edge_sel = '0;

    // Saturation / wrap on a 4-bit counter.
    do_reset();
    repeat (14) pulse(5'b00001);
    flush();
    check_val("sat14_cnt", cnt_of(0), 32'd14);
    check_val("sat14_flg", 32'(sat_flag[0]), 32'd0);
    pulse(5'b00001);
    flush();
    check_val("sat15_cnt", cnt_of(0), 32'd15);
`ifdef PTMCH_CNT_WRAP_EN
    check_val("sat15_flg", 32'(sat_flag[0]), 32'd0);
    sb_push("sat20_cnt", 32'd4);
`else
    check_val("sat15_flg", 32'(sat_flag[0]), 32'd1);
    sb_push("sat20_cnt", 32'd15);
`endif
    sb_push("sat20_flg", 32'd1);
    repeat (5) pulse(5'b00001);
    flush();
    sb_pop(cnt_of(0));
    sb_pop(32'(sat_flag[0]));
    clr_mask = 5'b00001;
    tick();
    clr_mask = '0;
    check_val("clr_cnt", cnt_of(0), 32'd0);
    check_val("clr_flg", 32'(sat_flag[0]), 32'd0);

    // Clear colliding with an event on ch4.
    do_reset();
    repeat (7) pulse(5'b10000);
    flush();
    check_val("col_pre", cnt_of(4), 32'd7);
    trg[4] = 1'b1;
    tick();
    tick();
    clr_mask = 5'b10000;
    tick();
    clr_mask = '0;
    check_val("col_clr", cnt_of(4), 32'd0);
    tick();
    trg[4] = 1'b0;
    repeat (3) tick();
    check_val("col_lost", cnt_of(4), 32'd0);
    pulse(5'b10000);
    flush();
    check_val("col_next", cnt_of(4), 32'd1);

    // Snapshot with atomic clear.
    do_reset();
    sb_push("snap_ch0", 32'd5);
    repeat (5) pulse(5'b00001);
    flush();
    snap_req = 1'b1;
    clr_mask = 5'b00001;
    tick();
    snap_req = 1'b0;
    clr_mask = '0;
    waited = 0;
    while (!snap_vld && waited < 8) begin
      tick();
      waited++;
    end
    check_val("snap_lat", 32'(waited), 32'd0);
    sb_pop(snap_of(0));
    check_val("snap_clr", cnt_of(0), 32'd0);
    tick();
    check_val("snap_vld_low", 32'(snap_vld), 32'd0);

    // Enable gating and no spurious count on re-enable.
    do_reset();
    cnt_en = 1'b0;
    repeat (3) pulse(5'b00001);
    flush();
    check_val("en_off", cnt_of(0), 32'd0);
    trg[0] = 1'b1;
    repeat (4) tick();
    cnt_en = 1'b1;
    repeat (3) tick();
    check_val("en_rise", cnt_of(0), 32'd0);
    trg[0] = 1'b0;
    repeat (3) tick();
    pulse(5'b00001);
    flush();
    check_val("en_on", cnt_of(0), 32'd1);

    // Reset in the middle of a pulse train, trigger held high through it.
    snap_req = 1'b1;
    tick();
    snap_req = 1'b0;
    pulse(5'b00001);
    trg[0] = 1'b1;
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    check_val("mid_cnt",  32'(cnt_out),  32'h0);
    check_val("mid_snap", 32'(snap_out), 32'h0);
    check_val("mid_sat",  32'(sat_flag), 32'h0);
    check_val("mid_vld",  32'(snap_vld), 32'h0);
    rst_n = 1'b1;
    repeat (3) tick();
    check_val("post_rst_rise", cnt_of(0), 32'd1);
    repeat (3) tick();
    check_val("post_rst_hold", cnt_of(0), 32'd1);
    check_val("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
